selection_sort_top: RTL and testbench

- Board-level top for the selection-sort practice design. Holds a 16 x 8-bit register array that comes out of reset preloaded with an unsorted pattern.
- After reset it sorts the array ascending with an on-chip selection-sort FSM, then lets the user inspect elements on the HEX displays.
- Users can load new values via SW/KEY and re-sort.
- Sits directly under the FPGA pin wrapper. Interfaces are switches, pushbuttons, LEDs and six 7-segment digits.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/hex_to_sseg.sv | 30 +++
 rtl/selection_sort_top.sv | 138 +++++++++++++
 tb/tb_selection_sort_top.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants, FSM state codes and the array preload pattern for the
// selection-sort board top.
package sort_pkg;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW_W = 3;

    localparam logic [SW_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [SW_W-1:0] ST_START = 3'd1;
    localparam logic [SW_W-1:0] ST_INIT  = 3'd2;
    localparam logic [SW_W-1:0] ST_SCAN  = 3'd3;
    localparam logic [SW_W-1:0] ST_SWAP  = 3'd4;
    localparam logic [SW_W-1:0] ST_DONE  = 3'd5;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    // Unsorted power-on contents: (37*i + 91) mod 256
    function automatic logic [W-1:0] preload(input int unsigned idx);
        logic [31:0] v;
        v = 32'(37 * idx + 91);
        return W'(v % 256);
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// 4-bit value to active-low 7-segment code, segment order {g,f,e,d,c,b,a}.
module hex_to_sseg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_sseg
);

    always_comb begin
        o_sseg = 7'h7F;
        case (i_hex)
            4'h0: o_sseg = 7'h40;
            4'h1: o_sseg = 7'h79;
            4'h2: o_sseg = 7'h24;
            4'h3: o_sseg = 7'h30;
            4'h4: o_sseg = 7'h19;
            4'h5: o_sseg = 7'h12;
            4'h6: o_sseg = 7'h02;
            4'h7: o_sseg = 7'h78;
            4'h8: o_sseg = 7'h00;
            4'h9: o_sseg = 7'h10;
            4'hA: o_sseg = 7'h08;
            4'hB: o_sseg = 7'h03;
            4'hC: o_sseg = 7'h46;
            4'hD: o_sseg = 7'h21;
            4'hE: o_sseg = 7'h06;
            4'hF: o_sseg = 7'h0E;
            default: o_sseg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/selection_sort_top.sv
// Board-level top: 16x8 register array, auto selection sort after reset,
// SW/KEY loading and re-sort, HEX/LEDR inspection.
module selection_sort_top
    import sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic [3:0]      r_key_s1;
    logic [3:0]      r_key_s2;
    logic [3:0]      r_key_prev;
    logic [W-1:0]    r_mem [N];
    logic [SW_W-1:0] r_state;
    logic [SW_W-1:0] w_state_nxt;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic [IW-1:0]   r_min;
    logic [IW-1:0]   r_wr_ptr;
    logic            r_done;

    logic [3:0]      w_press;
    logic            w_accept;
    logic            w_wr_req;
    logic            w_sort_req;
    logic            w_less;
    logic            w_busy;
    logic [W-1:0]    w_view;
    logic [3:0]      w_state_code;
    logic            w_unused;

    // Key synchroniser and falling-edge (press) detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s1   <= 4'hF;
            r_key_s2   <= 4'hF;
            r_key_prev <= 4'hF;
        end else begin
            r_key_s1   <= KEY;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
        end
    end

    assign w_press    = r_key_prev & ~r_key_s2;
    assign w_accept   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_wr_req   = w_accept & w_press[0];
    assign w_sort_req = w_accept & w_press[1] & ~w_press[0];
    assign w_less     = r_mem[r_j] < r_mem[r_min];
    assign w_busy     = (r_state == ST_START) || (r_state == ST_INIT) ||
                        (r_state == ST_SCAN)  || (r_state == ST_SWAP);
    assign w_unused   = ^{w_press[3:2], SW[9:8]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_START: w_state_nxt = ST_INIT;
            ST_INIT:  w_state_nxt = ST_SCAN;
            ST_SCAN:  if (r_j == IW'(N - 1)) w_state_nxt = ST_SWAP;
            ST_SWAP:  w_state_nxt = (r_i == IW'(N - 2)) ? ST_DONE : ST_INIT;
            ST_IDLE, ST_DONE: begin
                if (w_wr_req)
                    w_state_nxt = ST_IDLE;
                else if (w_sort_req)
                    w_state_nxt = ST_START;
            end
            default:  w_state_nxt = ST_START;
        endcase
    end

    // Sort datapath, user writes and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_START;
            r_i      <= '0;
            r_j      <= '0;
            r_min    <= '0;
            r_wr_ptr <= '0;
            r_done   <= 1'b0;
            for (int unsigned k = 0; k < N; k++)
                r_mem[k] <= preload(k);
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_START: r_i <= '0;
                ST_INIT: begin
                    r_min <= r_i;
                    r_j   <= r_i + IW'(1);
                end
                ST_SCAN: begin
                    if (w_less)
                        r_min <= r_j;
                    if (r_j != IW'(N - 1))
                        r_j <= r_j + IW'(1);
                end
                ST_SWAP: begin
                    r_mem[r_i]   <= r_mem[r_min];
                    r_mem[r_min] <= r_mem[r_i];
                    if (r_i == IW'(N - 2))
                        r_done <= 1'b1;
                    else
                        r_i <= r_i + IW'(1);
                end
                default: ;
            endcase
            if (w_wr_req) begin
                r_mem[r_wr_ptr] <= SW[W-1:0];
                r_wr_ptr        <= r_wr_ptr + IW'(1);
                r_done          <= 1'b0;
            end else if (w_sort_req) begin
                r_done <= 1'b0;
            end
        end
    end

    assign w_view       = r_mem[SW[IW-1:0]];
    assign w_state_code = (r_state == ST_IDLE) ? 4'd0 :
                          (r_state == ST_DONE) ? 4'd2 : 4'd1;

    assign LEDR = {r_done, w_busy, 4'b0000, r_wr_ptr};
    assign HEX3 = SSEG_BLANK;

    hex_to_sseg u_hex0 (.i_hex(w_view[3:0]),   .o_sseg(HEX0));
    hex_to_sseg u_hex1 (.i_hex(w_view[7:4]),   .o_sseg(HEX1));
    hex_to_sseg u_hex2 (.i_hex(SW[3:0]),       .o_sseg(HEX2));
    hex_to_sseg u_hex4 (.i_hex(r_wr_ptr),      .o_sseg(HEX4));
    hex_to_sseg u_hex5 (.i_hex(w_state_code),  .o_sseg(HEX5));

endmodule

// File: tb/tb_selection_sort_top.sv
// Directed bench for selection_sort_top: auto-sort, latency, writes, re-sort,
// busy-key rejection, pointer wrap and mid-sort reset.
module tb_selection_sort_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_pass  = 0;
    int n_total = 0;
    int cnt;
    logic first_busy;
    logic [7:0] sorted_ref [16];

    selection_sort_top dut (
        .clk(clk), .rst(rst), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_mem(input logic [3:0] idx, input logic [7:0] exp);
        SW = {6'b0, idx};
        #1;
        chk($sformatf("mem[%0d]", idx), {18'b0, HEX1, HEX0}, {18'b0, seg(exp[7:4]), seg(exp[3:0])});
    endtask

    task automatic press(input logic [3:0] mask, input logic [7:0] data);
        @(negedge clk);
        SW  = {2'b00, data};
        KEY = ~mask;
        repeat (4) @(negedge clk);
        KEY = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        first_busy = 1'b0;
        while (!LEDR[9] && c < 400) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) first_busy = LEDR[8];
        end
        chk("sort_done", {31'b0, LEDR[9]}, 32'd1);
        @(negedge clk);
    endtask

    task automatic sweep_sorted(input string tag);
        for (int k = 0; k < 16; k++) begin
            SW = 10'(k);
            #1;
            chk($sformatf("%s[%0d]", tag, k), {18'b0, HEX1, HEX0},
                {18'b0, seg(sorted_ref[k][7:4]), seg(sorted_ref[k][3:0])});
        end
    endtask

    initial begin
        sorted_ref = '{8'h14, 8'h17, 8'h39, 8'h3C, 8'h5B, 8'h5E, 8'h61, 8'h80,
                       8'h83, 8'h86, 8'hA5, 8'hA8, 8'hCA, 8'hCD, 8'hEF, 8'hF2};
        rst = 1'b1;
        KEY = 4'hF;
        SW  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ledr", {22'b0, LEDR}, 32'h100);
        chk("rst_hex3", {25'b0, HEX3}, 32'h7F);
        chk("rst_hex4", {25'b0, HEX4}, {25'b0, seg(4'h0)});
        chk("rst_hex5", {25'b0, HEX5}, {25'b0, seg(4'h1)});
        chk_mem(4'd0, 8'h5B);
        chk_mem(4'd4, 8'hEF);

        // Auto-sort latency and result
        rst = 1'b0;
        wait_done(cnt);
        chk("busy_cycle1", {31'b0, first_busy}, 32'd1);
        chk("sort_latency", cnt, 32'd151);
        chk("done_not_busy", {31'b0, LEDR[8]}, 32'd0);
        chk("done_hex5", {25'b0, HEX5}, {25'b0, seg(4'h2)});
        sweep_sorted("sort1");
        SW = 10'd9;
        #1;
        chk("hex2_index", {25'b0, HEX2}, {25'b0, seg(4'h9)});

        // Writes with equal keys and extremes, then re-sort
        press(4'b0001, 8'h00);
        press(4'b0001, 8'hFF);
        press(4'b0001, 8'h00);
        chk("wr_ptr3", {28'b0, LEDR[3:0]}, 32'd3);
        chk("wr_clear_done", {31'b0, LEDR[9]}, 32'd0);
        chk("idle_hex5", {25'b0, HEX5}, {25'b0, seg(4'h0)});
        chk("idle_hex4", {25'b0, HEX4}, {25'b0, seg(4'h3)});
        press(4'b0010, 8'h00);
        wait_done(cnt);
        chk_mem(4'd0,  8'h00);
        chk_mem(4'd1,  8'h00);
        chk_mem(4'd2,  8'h3C);
        chk_mem(4'd15, 8'hFF);

        // Keys pressed while busy are discarded
        press(4'b0010, 8'h00);
        chk("busy_running", {31'b0, LEDR[8]}, 32'd1);
        press(4'b0011, 8'h77);
        chk("busy_ptr", {28'b0, LEDR[3:0]}, 32'd3);
        wait_done(cnt);
        chk("busy_ptr_after", {28'b0, LEDR[3:0]}, 32'd3);
        chk_mem(4'd0,  8'h00);
        chk_mem(4'd3,  8'h5B);
        chk_mem(4'd15, 8'hFF);

        // Simultaneous write+sort in DONE: write wins
        press(4'b0011, 8'h01);
        chk("both_ptr", {28'b0, LEDR[3:0]}, 32'd4);
        chk("both_idle", {22'b0, LEDR}, 32'h004);
        chk_mem(4'd3, 8'h01);
        chk_mem(4'd2, 8'h3C);

        // Fill to wrap, then overwrite entry 0
        for (int k = 0; k < 12; k++)
            press(4'b0001, 8'(8'h20 + k));
        chk("wrap_ptr0", {28'b0, LEDR[3:0]}, 32'd0);
        chk_mem(4'd4,  8'h20);
        chk_mem(4'd15, 8'h2B);
        press(4'b0001, 8'hAB);
        chk("wrap_ptr1", {28'b0, LEDR[3:0]}, 32'd1);
        chk_mem(4'd0, 8'hAB);

        // Reset in the middle of a sort restores the preload and re-sorts
        press(4'b0010, 8'h00);
        repeat (40) @(negedge clk);
        chk("mid_busy", {31'b0, LEDR[8]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ledr", {22'b0, LEDR}, 32'h100);
        chk_mem(4'd0,  8'h5B);
        chk_mem(4'd5,  8'h14);
        chk_mem(4'd15, 8'h86);
        @(negedge clk);
        rst = 1'b0;
        wait_done(cnt);
        chk("resort_latency", cnt, 32'd151);
        sweep_sorted("sort2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
